// File: rtl/multdiv_controller.sv
// multdiv_controller: sequences one multiply/divide op at a time between the
// execute stage and the multdiv unit.
//   clock_i/reset_i        : clock, asynchronous active-high reset
//   issue_*_i, flush_i     : op from execute (valid, kind, rd, operands), pipeline flush
//   stall_o, busy_o        : pipeline hold (combinational in IDLE), controller not idle
//   md_ctrl_*_o, md_operand_*_o : start pulse and latched operands to multdiv
//   md_result_i, md_exception_i, md_ready_i : multdiv result handshake
//   wb_*_o                 : writeback result, one-cycle valid
module multdiv_controller #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned RD_W    = 5
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            issue_valid_i,
   input  logic            issue_is_div_i,
   input  logic [RD_W-1:0] issue_rd_i,
   input  logic [31:0]     issue_a_i,
   input  logic [31:0]     issue_b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            md_ctrl_mult_o,
   output logic            md_ctrl_div_o,
   output logic [31:0]     md_operand_a_o,
   output logic [31:0]     md_operand_b_o,
   input  logic [31:0]     md_result_i,
   input  logic            md_exception_i,
   input  logic            md_ready_i,
   output logic            wb_valid_o,
   output logic [RD_W-1:0] wb_rd_o,
   output logic [31:0]     wb_data_o,
   output logic            wb_exception_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   // One-hot so every state decode is a single flop bit.
   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_START = 4'b0010,
      S_WAIT  = 4'b0100,
      S_DONE  = 4'b1000
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       op_a_q, op_a_d;
   logic [31:0]       op_b_q, op_b_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic              is_div_q, is_div_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
   logic              wb_exc_q, wb_exc_d;

   logic accept;
   logic timed_out;

   assign accept    = (state_q == S_IDLE) && issue_valid_i && !flush_i;
   assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next state; flush beats ready beats timeout. Ready is ignored in START
   // because multdiv may still be showing the previous op's ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_START;
         S_START: state_d = flush_i ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (flush_i)         state_d = S_IDLE;
            else if (md_ready_i) state_d = S_DONE;
            else if (timed_out)  state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; stall in IDLE holds the op during its accept cycle.
   always_comb begin
      stall_o        = 1'b0;
      busy_o         = (state_q != S_IDLE);
      md_ctrl_mult_o = 1'b0;
      md_ctrl_div_o  = 1'b0;
      wb_valid_o     = 1'b0;
      case (state_q)
         S_IDLE:  stall_o = issue_valid_i && !flush_i;
         S_START: begin
            stall_o        = 1'b1;
            md_ctrl_mult_o = !is_div_q;
            md_ctrl_div_o  = is_div_q;
         end
         S_WAIT:  stall_o = 1'b1;
         S_DONE:  wb_valid_o = 1'b1;
         default: stall_o = 1'b0;
      endcase
   end

   // Datapath next values: operand latch on accept, watchdog, result capture.
   always_comb begin
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      rd_d      = rd_q;
      is_div_d  = is_div_q;
      cnt_d     = cnt_q;
      wb_data_d = wb_data_q;
      wb_rd_d   = wb_rd_q;
      wb_exc_d  = wb_exc_q;
      if (accept) begin
         op_a_d   = issue_a_i;
         op_b_d   = issue_b_i;
         rd_d     = issue_rd_i;
         is_div_d = issue_is_div_i;
      end
      if (state_q == S_START) cnt_d = '0;
      if (state_q == S_WAIT) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (!flush_i) begin
            if (md_ready_i) begin
               wb_data_d = md_result_i;
               wb_exc_d  = md_exception_i;
               wb_rd_d   = rd_q;
            end else if (timed_out) begin
               wb_data_d = '0;
               wb_exc_d  = 1'b1;
               wb_rd_d   = rd_q;
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         op_a_q    <= '0;
         op_b_q    <= '0;
         rd_q      <= '0;
         is_div_q  <= 1'b0;
         cnt_q     <= '0;
         wb_data_q <= '0;
         wb_rd_q   <= '0;
         wb_exc_q  <= 1'b0;
      end else begin
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         rd_q      <= rd_d;
         is_div_q  <= is_div_d;
         cnt_q     <= cnt_d;
         wb_data_q <= wb_data_d;
         wb_rd_q   <= wb_rd_d;
         wb_exc_q  <= wb_exc_d;
      end
   end

   assign md_operand_a_o = op_a_q;
   assign md_operand_b_o = op_b_q;
   assign wb_data_o      = wb_data_q;
   assign wb_rd_o        = wb_rd_q;
   assign wb_exception_o = wb_exc_q;

endmodule
